// File: rtl/mar_pkg.sv
// Shared definitions for the memory address register controller:
// opcode encodings, FSM state type and default parameter values.
package mar_pkg;

   localparam int MAR_ADDR_W_DEF    = 8;
   localparam int MAR_OFF_W_DEF     = 4;
   localparam int MAR_TIMEOUT_DEF   = 15;
   localparam int MAR_BURST_LEN_DEF = 4;

   localparam logic [2:0] MAR_HOLD     = 3'b000;
   localparam logic [2:0] MAR_LOAD_MBR = 3'b001;
   localparam logic [2:0] MAR_LOAD_PC  = 3'b010;
   localparam logic [2:0] MAR_LOAD_IR  = 3'b011;
   localparam logic [2:0] MAR_INC      = 3'b100;
   localparam logic [2:0] MAR_INDEX    = 3'b101;
   localparam logic [2:0] MAR_DEC      = 3'b110;
   localparam logic [2:0] MAR_BURST    = 3'b111;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } state_e;

endpackage

// File: rtl/mar_addr_alu.sv
// Combinational next-address unit: source selection, increment, decrement
// and base+signed-offset indexing, with an overflow/underflow flag.
module mar_addr_alu
   import mar_pkg::*;
#(
   parameter int ADDR_W = MAR_ADDR_W_DEF,
   parameter int OFF_W  = MAR_OFF_W_DEF
) (
   input  logic [2:0]        op_i,
   input  logic [ADDR_W-1:0] cur_addr_i,
   input  logic [ADDR_W-1:0] from_mbr_i,
   input  logic [ADDR_W-1:0] from_pc_i,
   input  logic [ADDR_W-1:0] from_ir_i,
   input  logic [OFF_W-1:0]  offset_i,
   output logic [ADDR_W-1:0] next_addr_o,
   output logic              wrap_o
);

   // Widened sums: one extra bit catches the increment carry; two extra bits
   // hold base+offset as a signed value so both carry-out and borrow show up
   // as a non-zero top pair.
   logic [ADDR_W:0]   inc_sum;
   logic [ADDR_W+1:0] idx_sum;

   assign inc_sum = {1'b0, cur_addr_i} + (ADDR_W+1)'(1);
   assign idx_sum = {2'b00, from_mbr_i}
                  + {{(ADDR_W+2-OFF_W){offset_i[OFF_W-1]}}, offset_i};

   // Select the next address and flag modulo wrap-around.
   always_comb begin
      next_addr_o = cur_addr_i;
      wrap_o      = 1'b0;
      case (op_i)
         MAR_LOAD_MBR: next_addr_o = from_mbr_i;
         MAR_LOAD_PC:  next_addr_o = from_pc_i;
         MAR_LOAD_IR:  next_addr_o = from_ir_i;
         MAR_INC: begin
            next_addr_o = inc_sum[ADDR_W-1:0];
            wrap_o      = inc_sum[ADDR_W];
         end
         MAR_INDEX: begin
            next_addr_o = idx_sum[ADDR_W-1:0];
            wrap_o      = |idx_sum[ADDR_W+1:ADDR_W];
         end
         MAR_DEC: begin
            next_addr_o = cur_addr_i - ADDR_W'(1);
            wrap_o      = (cur_addr_i == '0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mar_ctrl.sv
// Memory address register with request/acknowledge handshake and timeout.
// Optional macro MAR_BURST_EN turns control 111 into a BURST_LEN-beat
// incrementing burst; without it 111 behaves as HOLD.
module mar_ctrl
   import mar_pkg::*;
#(
   parameter int ADDR_W    = MAR_ADDR_W_DEF,
   parameter int OFF_W     = MAR_OFF_W_DEF,
   parameter int TIMEOUT   = MAR_TIMEOUT_DEF,
   parameter int BURST_LEN = MAR_BURST_LEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        control,
   input  logic [ADDR_W-1:0] from_mbr,
   input  logic [ADDR_W-1:0] from_pc,
   input  logic [ADDR_W-1:0] from_ir,
   input  logic [OFF_W-1:0]  offset,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] to_memory,
   output logic              mem_req,
   output logic              busy,
   output logic              wrap,
   output logic              err
);

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mar_ctrl: TIMEOUT must be 1..255");
   end
   if (BURST_LEN < 2 || BURST_LEN > 16) begin : g_bad_burst
      $error("mar_ctrl: BURST_LEN must be 2..16");
   end

   // Last counter value before the abort edge: mem_req stays up TIMEOUT cycles.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              wrap_q, wrap_d;
   logic              err_q, err_d;
   logic [2:0]        alu_op;
   logic [ADDR_W-1:0] alu_addr;
   logic              alu_wrap;
   logic              is_op;

`ifdef MAR_BURST_EN
   localparam logic [4:0] BEAT_LAST = 5'(BURST_LEN - 1);
   logic       burst_q, burst_d;
   logic [4:0] beat_q, beat_d;
`endif

   mar_addr_alu #(
      .ADDR_W (ADDR_W),
      .OFF_W  (OFF_W)
   ) u_alu (
      .op_i        (alu_op),
      .cur_addr_i  (addr_q),
      .from_mbr_i  (from_mbr),
      .from_pc_i   (from_pc),
      .from_ir_i   (from_ir),
      .offset_i    (offset),
      .next_addr_o (alu_addr),
      .wrap_o      (alu_wrap)
   );

   // State and datapath registers; reset aborts any access at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef MAR_BURST_EN
         burst_q <= 1'b0;
         beat_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
`ifdef MAR_BURST_EN
         burst_q <= burst_d;
         beat_q  <= beat_d;
`endif
      end
   end

   // Next-state logic: accept ops only in IDLE, wait for ack or timeout in REQ.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      alu_op  = control;
      is_op   = (control != MAR_HOLD);
`ifndef MAR_BURST_EN
      if (control == MAR_BURST) is_op = 1'b0;
`else
      burst_d = burst_q;
      beat_d  = beat_q;
      // During a burst the ALU only ever advances the address by one.
      if (state_q == S_REQ) alu_op = MAR_INC;
`endif
      case (state_q)
         S_IDLE: begin
            if (is_op) begin
               addr_d  = alu_addr;
               wrap_d  = alu_wrap;
               cnt_d   = '0;
               state_d = S_REQ;
`ifdef MAR_BURST_EN
               burst_d = (control == MAR_BURST);
               beat_d  = '0;
`endif
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               state_d = S_IDLE;
`ifdef MAR_BURST_EN
               if (burst_q && beat_q != BEAT_LAST) begin
                  state_d = S_REQ;
                  addr_d  = alu_addr;
                  wrap_d  = alu_wrap;
                  cnt_d   = '0;
                  beat_d  = beat_q + 5'd1;
               end
`endif
            end else if (cnt_q == TO_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign to_memory = addr_q;
   assign mem_req   = (state_q == S_REQ);
   assign busy      = (state_q == S_REQ);
   assign wrap      = wrap_q;
   assign err       = err_q;

endmodule
